// File: rtl/apb_mig_pkg.sv
// Shared types for the APB side of the MIG bridge: bus types, requester state and
// the request/response records carried through the APB requester.
package apb_mig_pkg;

    typedef logic [31:0] apb_addr_t;
    typedef logic [31:0] data_t;
    typedef logic [$bits(data_t)/8-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    typedef struct packed {
        apb_addr_t addr;
        logic      write;
        data_t     wdata;
        strb_t     strb;
    } apb_req_t;

    typedef struct packed {
        data_t rdata;
        logic  slverr;
        logic  tmo;
    } apb_rsp_t;

    // A disabled watchdog (0 cycles) still gets a 1-bit counter so the port widths stay legal.
    function automatic int wdog_width(input int cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB4 bus bundle between the requester (master) and the MIG bridge front-end (slave).
interface apb_if;
    import apb_mig_pkg::*;

    apb_addr_t paddr;
    data_t     pwdata;
    logic      pwrite;
    logic      psel;
    logic      penable;
    strb_t     pstrb;
    data_t     prdata;
    logic      pready;
    logic      pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_mig_master.sv
// APB4 requester: one command in, one single APB transfer, one response out,
// with a PREADY watchdog so a hung slave cannot stall the command stream.
module apb_mig_master
    import apb_mig_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic      pclk_i,
    input  logic      preset_n,
    input  logic      req_valid_i,
    output logic      req_ready_o,
    input  apb_addr_t req_addr_i,
    input  logic      req_write_i,
    input  data_t     req_wdata_i,
    input  strb_t     req_strb_i,
    output logic      rsp_valid_o,
    input  logic      rsp_ready_i,
    output data_t     rsp_rdata_o,
    output logic      rsp_slverr_o,
    output logic      rsp_tmo_o,
    apb_if.master     apb
);

    localparam int              WD_W    = wdog_width(TIMEOUT_CYCLES);
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_mst_state_e  state_reg;
    apb_req_t        req_reg;
    apb_rsp_t        rsp_reg;
    logic [WD_W-1:0] wdog_reg;
    logic            psel_reg;
    logic            penable_reg;
    logic            req_ready_reg;
    logic            rsp_valid_reg;

    always_ff @(posedge pclk_i) begin
        if (!preset_n) begin
            // Everything clears except req_ready, which must announce the IDLE state.
            state_reg     <= IDLE;
            req_reg       <= '0;
            rsp_reg       <= '0;
            wdog_reg      <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        // Reads carry zero data and strobes onto the bus.
                        req_reg.addr  <= req_addr_i;
                        req_reg.write <= req_write_i;
                        req_reg.wdata <= req_write_i ? req_wdata_i : '0;
                        req_reg.strb  <= req_write_i ? req_strb_i : '0;
                        wdog_reg      <= '0;
                        psel_reg      <= 1'b1;
                        req_ready_reg <= 1'b0;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    // A slave completing in the last allowed cycle beats the watchdog.
                    if (apb.pready) begin
                        rsp_reg.rdata  <= req_reg.write ? '0 : apb.prdata;
                        rsp_reg.slverr <= apb.pslverr;
                        rsp_reg.tmo    <= 1'b0;
                        psel_reg       <= 1'b0;
                        penable_reg    <= 1'b0;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else if (WD_EN && (wdog_reg == WD_LAST)) begin
                        rsp_reg        <= '{rdata: '0, slverr: 1'b1, tmo: 1'b1};
                        psel_reg       <= 1'b0;
                        penable_reg    <= 1'b0;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else if (WD_EN) begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_reg;
    assign rsp_valid_o  = rsp_valid_reg;
    assign rsp_rdata_o  = rsp_reg.rdata;
    assign rsp_slverr_o = rsp_reg.slverr;
    assign rsp_tmo_o    = rsp_reg.tmo;

    assign apb.paddr    = req_reg.addr;
    assign apb.pwrite   = req_reg.write;
    assign apb.pwdata   = req_reg.wdata;
    assign apb.pstrb    = req_reg.strb;
    assign apb.psel     = psel_reg;
    assign apb.penable  = penable_reg;

endmodule

// File: tb/tb_apb_mig_master.sv
// Directed bench for apb_mig_master: a transaction-level model predicts bus and
// response behaviour every cycle, and literal expectations pin the key scenarios.
module tb_apb_mig_master;
    import apb_mig_pkg::*;

    localparam int TMO = 4;

    logic      clk = 1'b0;
    logic      preset_n = 1'b0;
    logic      req_valid = 1'b0;
    logic      req_ready;
    apb_addr_t req_addr = '0;
    logic      req_write = 1'b0;
    data_t     req_wdata = '0;
    strb_t     req_strb = '0;
    logic      rsp_valid;
    logic      rsp_ready = 1'b1;
    data_t     rsp_rdata;
    logic      rsp_slverr;
    logic      rsp_tmo;

    apb_if apb();

    apb_mig_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .pclk_i      (clk),
        .preset_n    (preset_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_slverr_o(rsp_slverr),
        .rsp_tmo_o   (rsp_tmo),
        .apb         (apb)
    );

    always #5 clk = ~clk;

    // slave behaviour requested for the command being presented
    int    nxt_wait = 0;
    data_t nxt_rdata = '0;
    logic  nxt_err = 1'b0;

    // events seen before an edge, applied to the model on that edge
    logic      rst_pend = 1'b0, acc_pend = 1'b0, hs_pend = 1'b0;
    apb_addr_t pc_addr = '0;
    logic      pc_write = 1'b0;
    data_t     pc_wdata = '0;
    strb_t     pc_strb = '0;
    int        pc_wait = 0;
    data_t     pc_rdata = '0;
    logic      pc_err = 1'b0;

    // transaction model
    logic      rst_seen = 1'b0;
    int        outstanding = 0, age = 0, nacc = 0, cur_wait = 0;
    data_t     cur_rdata = '0;
    logic      cur_err = 1'b0;
    data_t     exp_rdata = '0;
    logic      exp_slverr = 1'b0, exp_tmo = 1'b0;
    apb_addr_t last_addr = '0;
    logic      last_write = 1'b0;
    data_t     last_wdata = '0;
    strb_t     last_strb = '0;
    int        acc_count = 0, rsp_count = 0, cyc = 0, last_acc_cyc = -1, min_gap = 1000;

    // observations of the current command
    logic      rv_seen = 1'b0;
    int        obs_lat = 0, obs_pen = 0;
    data_t     obs_rdata = '0;
    logic      obs_slverr = 1'b0, obs_tmo = 1'b0;

    int        acc_cnt = 0;
    int        n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // model update on each rising edge
    always @(posedge clk) begin
        cyc++;
        if (rst_pend) begin
            rst_seen = 1'b1; outstanding = 0; age = 0; last_acc_cyc = -1;
            last_addr = '0; last_write = 1'b0; last_wdata = '0; last_strb = '0;
        end else begin
            if (hs_pend) begin
                outstanding = 0;
                rsp_count++;
            end
            if (acc_pend) begin
                outstanding = 1; age = 1;
                cur_wait = pc_wait; cur_rdata = pc_rdata; cur_err = pc_err;
                exp_tmo    = (TMO != 0) && (pc_wait + 1 > TMO);
                nacc       = exp_tmo ? TMO : pc_wait + 1;
                exp_slverr = exp_tmo | pc_err;
                exp_rdata  = (exp_tmo || pc_write) ? '0 : pc_rdata;
                last_addr  = pc_addr;
                last_write = pc_write;
                last_wdata = pc_write ? pc_wdata : '0;
                last_strb  = pc_write ? pc_strb : '0;
                if (last_acc_cyc >= 0 && cyc - last_acc_cyc < min_gap) min_gap = cyc - last_acc_cyc;
                last_acc_cyc = cyc;
                acc_count++;
                rv_seen = 1'b0; obs_pen = 0;
            end else if (outstanding != 0) begin
                age++;
            end
        end
    end

    // compare, slave and event capture on each falling edge
    always @(negedge clk) begin
        logic e_psel, e_pen, e_rv;
        e_psel = (outstanding != 0) && (age >= 1) && (age <= 1 + nacc);
        e_pen  = (outstanding != 0) && (age >= 2) && (age <= 1 + nacc);
        e_rv   = (outstanding != 0) && (age >= 2 + nacc);
        if (rst_seen) begin
            chk("req_ready", req_ready, outstanding == 0);
            chk("psel", apb.psel, e_psel);
            chk("penable", apb.penable, e_pen);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("paddr", apb.paddr, last_addr);
            chk("pwrite", apb.pwrite, last_write);
            chk("pwdata", apb.pwdata, last_wdata);
            chk("pstrb", apb.pstrb, last_strb);
            if (e_rv) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_slverr", rsp_slverr, exp_slverr);
                chk("rsp_tmo", rsp_tmo, exp_tmo);
            end
        end
        if (apb.penable) obs_pen++;
        if (rsp_valid) begin
            if (!rv_seen) begin
                rv_seen = 1'b1;
                obs_lat = age;
            end
            obs_rdata = rsp_rdata; obs_slverr = rsp_slverr; obs_tmo = rsp_tmo;
        end
        // slave: completes in ACCESS cycle cur_wait+1, drives junk elsewhere
        if (apb.psel && apb.penable) begin
            acc_cnt++;
            apb.pready = (acc_cnt == cur_wait + 1);
        end else begin
            acc_cnt = 0;
            apb.pready = 1'($urandom_range(0, 1));
        end
        if (apb.pready && apb.psel && apb.penable) begin
            apb.prdata = cur_rdata; apb.pslverr = cur_err;
        end else begin
            apb.prdata = $urandom; apb.pslverr = 1'($urandom_range(0, 1));
        end
        rst_pend = !preset_n;
        acc_pend = req_valid && (outstanding == 0);
        hs_pend  = e_rv && rsp_ready;
        pc_addr = req_addr; pc_write = req_write; pc_wdata = req_wdata; pc_strb = req_strb;
        pc_wait = nxt_wait; pc_rdata = nxt_rdata; pc_err = nxt_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic present(input apb_addr_t a, input logic w, input data_t d, input strb_t s,
                           input int wt, input data_t rd, input logic e);
        req_addr = a; req_write = w; req_wdata = d; req_strb = s;
        nxt_wait = wt; nxt_rdata = rd; nxt_err = e;
        req_valid = 1'b1;
    endtask

    task automatic wait_accept(input int a0);
        for (int i = 0; i < 200; i++) begin
            if (acc_count != a0) begin
                req_valid = 1'b0;
                return;
            end
            tick(1);
        end
        req_valid = 1'b0;
        fail_now("accept");
    endtask

    task automatic send(input apb_addr_t a, input logic w, input data_t d, input strb_t s,
                        input int wt, input data_t rd, input logic e);
        int a0;
        a0 = acc_count;
        present(a, w, d, s, wt, rd, e);
        tick(1);
        wait_accept(a0);
        $display("cmd %0d: addr=%08h write=%0b wdata=%08h strb=%h wait=%0d", a0, a, w, d, s, wt);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 300; i++) begin
            if (rsp_count >= target) begin
                $display("rsp %0d: rdata=%08h slverr=%0b tmo=%0b lat=%0d penable=%0d",
                         target, obs_rdata, obs_slverr, obs_tmo, obs_lat, obs_pen);
                return;
            end
            tick(1);
        end
        fail_now("response");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, r0;
        apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
        tick(3);
        chk("rst_psel", apb.psel, 0);
        chk("rst_penable", apb.penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_paddr", apb.paddr, 0);
        preset_n = 1'b1;
        tick(2);

        // zero-wait write
        send(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        wait_rsp(1);
        chk("wr_lat", obs_lat, 3);
        chk("wr_pen", obs_pen, 1);
        chk("wr_rdata", obs_rdata, 0);
        chk("wr_slverr", obs_slverr, 0);

        // read, 3 wait states, error
        send(32'h20, 1'b0, 32'h0, 4'h0, 3, 32'hA5A5_0001, 1'b1);
        wait_rsp(2);
        chk("rd_pen", obs_pen, 4);
        chk("rd_rdata", obs_rdata, 32'hA5A5_0001);
        chk("rd_slverr", obs_slverr, 1);
        chk("rd_tmo", obs_tmo, 0);

        // hung slave: watchdog fires after 4 ACCESS cycles
        send(32'h30, 1'b0, 32'h0, 4'h0, 100, 32'h1234_5678, 1'b0);
        wait_rsp(3);
        chk("wd_pen", obs_pen, 4);
        chk("wd_lat", obs_lat, 6);
        chk("wd_rdata", obs_rdata, 0);
        chk("wd_slverr", obs_slverr, 1);
        chk("wd_tmo", obs_tmo, 1);

        // pready in the last allowed ACCESS cycle wins
        send(32'h34, 1'b1, 32'h0BAD_F00D, 4'h3, 3, 32'h0, 1'b0);
        wait_rsp(4);
        chk("edge_pen", obs_pen, 4);
        chk("edge_tmo", obs_tmo, 0);
        chk("edge_slverr", obs_slverr, 0);

        // response backpressure with a second command waiting
        rsp_ready = 1'b0;
        send(32'h40, 1'b1, 32'hCAFE_0040, 4'h5, 1, 32'h0, 1'b0);
        a0 = acc_count;
        present(32'h44, 1'b0, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0);
        for (int i = 0; i < 50 && !rsp_valid; i++) tick(1);
        if (!rsp_valid) fail_now("bp_rsp_valid");
        repeat (5) begin
            tick(1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 0);
        end
        rsp_ready = 1'b1;
        tick(1);
        wait_accept(a0);
        wait_rsp(6);
        chk("bp_b_rdata", obs_rdata, 32'h5555_AAAA);

        // reset in the middle of ACCESS
        r0 = rsp_count;
        send(32'h50, 1'b0, 32'h0, 4'h0, 100, 32'h0, 1'b0);
        for (int i = 0; i < 20 && !apb.penable; i++) tick(1);
        tick(1);
        preset_n = 1'b0;
        tick(1);
        preset_n = 1'b1;
        chk("mrst_psel", apb.psel, 0);
        chk("mrst_penable", apb.penable, 0);
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_req_ready", req_ready, 1);
        tick(6);
        chk("mrst_no_rsp", rsp_valid, 0);
        send(32'h60, 1'b1, 32'h6060_6060, 4'hC, 0, 32'h0, 1'b0);
        wait_rsp(r0 + 1);
        chk("mrst_next_lat", obs_lat, 3);

        // back-to-back random commands
        min_gap = 1000;
        r0 = rsp_count;
        for (int i = 0; i < 8; i++) begin
            send({$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom,
                 1'($urandom_range(0, 1)));
        end
        wait_rsp(r0 + 8);
        chk("b2b_gap_ge4", min_gap >= 4, 1);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
